// File: rtl/btb_pkg.sv
// Shared BTB definitions: default geometry, controller state encoding and
// the write-port record exchanged between the update controller and the BTB.
package btb_pkg;

  localparam int WORD_SIZE = 16;  // PC / target width
  localparam int IDX_SIZE  = 8;   // BTB index width (2**IDX_SIZE entries)

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } btb_state_e;

  // One BTB write-port transaction.
  typedef struct packed {
    logic                          we;
    logic [IDX_SIZE-1:0]           idx;
    logic [WORD_SIZE-IDX_SIZE-1:0] tag;
    logic [WORD_SIZE-1:0]          target;
    logic                          vld;
  } btb_wr_t;

endpackage

// File: rtl/btb_arb2.sv
// Two-way fixed-priority arbiter (EX over ID) with a starvation counter that
// hands priority to ID once it has been refused STARVE_LIMIT cycles in a row.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   en                   arbitration enabled (controller in RUN)
//   ex_valid, id_valid   requests
//   ex_grant, id_grant   combinational grants
//   starve               current refusal count of ID
module btb_arb2 #(
  parameter int STARVE_LIMIT = 4,
  parameter int SW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          ex_valid,
  input  logic          id_valid,
  output logic          ex_grant,
  output logic          id_grant,
  output logic [SW-1:0] starve
);

  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic id_pri;

  always_comb begin
    id_pri   = id_valid && (starve == LIMIT);
    ex_grant = en && ex_valid && !id_pri;
    id_grant = en && id_valid && (!ex_valid || id_pri);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve <= '0;
    end else if (!id_valid || id_grant) begin
      starve <= '0;
    end else if (starve != LIMIT) begin
      starve <= starve + 1'b1;
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: sweeps the BTB clear after reset or flush_req, then
// arbitrates ID/EX update requests onto the single registered BTB write port.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   flush_req                         invalidate whole BTB
//   ex_valid/taken/pc/target, ex_ready  resolved-branch update request
//   id_valid/pc/target, id_ready        decoded-jump update request
//   btb_we/idx/tag/target/vld         registered BTB write port
//   busy                              clear sweep in progress
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int WORD_SIZE    = btb_pkg::WORD_SIZE,
  parameter int IDX_SIZE     = btb_pkg::IDX_SIZE,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush_req,
  input  logic                          ex_valid,
  input  logic                          ex_taken,
  input  logic [WORD_SIZE-1:0]          ex_pc,
  input  logic [WORD_SIZE-1:0]          ex_target,
  output logic                          ex_ready,
  input  logic                          id_valid,
  input  logic [WORD_SIZE-1:0]          id_pc,
  input  logic [WORD_SIZE-1:0]          id_target,
  output logic                          id_ready,
  output logic                          btb_we,
  output logic [IDX_SIZE-1:0]           btb_idx,
  output logic [WORD_SIZE-IDX_SIZE-1:0] btb_tag,
  output logic [WORD_SIZE-1:0]          btb_target,
  output logic                          btb_vld,
  output logic                          busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [IDX_SIZE:0] SWEEP_LAST = (IDX_SIZE+1)'((1 << IDX_SIZE) - 1);

  btb_state_e          state;
  logic [IDX_SIZE:0]   sweep;
  logic                clr_tail;  // last clear write is on the port this cycle
  logic                ex_grant;
  logic                id_grant;
  logic [SW-1:0]       starve;

  btb_arb2 #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .SW          (SW)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (reset_n && (state == RUN)),
    .ex_valid(ex_valid),
    .id_valid(id_valid),
    .ex_grant(ex_grant),
    .id_grant(id_grant),
    .starve  (starve)
  );

  assign ex_ready = ex_grant;
  assign id_ready = id_grant;
  // The final clear is presented one cycle after the FSM has moved to RUN,
  // so busy is stretched by clr_tail to cover it.
  assign busy     = !reset_n || (state == FLUSH) || clr_tail;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= FLUSH;
      sweep      <= '0;
      clr_tail   <= 1'b0;
      btb_we     <= 1'b0;
      btb_idx    <= '0;
      btb_tag    <= '0;
      btb_target <= '0;
      btb_vld    <= 1'b0;
    end else begin
      clr_tail <= (state == FLUSH);
      case (state)
        FLUSH: begin
          btb_we     <= 1'b1;
          btb_idx    <= sweep[IDX_SIZE-1:0];
          btb_tag    <= '0;
          btb_target <= '0;
          btb_vld    <= 1'b0;
          if (flush_req) begin
            sweep <= '0;
          end else if (sweep == SWEEP_LAST) begin
            state <= RUN;
            sweep <= '0;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end
        RUN: begin
          btb_we <= ex_grant || id_grant;
          if (ex_grant) begin
            btb_idx    <= ex_pc[IDX_SIZE-1:0];
            btb_tag    <= ex_pc[WORD_SIZE-1:IDX_SIZE];
            btb_target <= ex_taken ? ex_target : '0;
            btb_vld    <= ex_taken;
          end else if (id_grant) begin
            btb_idx    <= id_pc[IDX_SIZE-1:0];
            btb_tag    <= id_pc[WORD_SIZE-1:IDX_SIZE];
            btb_target <= id_target;
            btb_vld    <= 1'b1;
          end
          if (flush_req) begin
            state <= FLUSH;
            sweep <= '0;
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
module tb_btb_update_ctrl;

  localparam int LIMIT = 4;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_req;
  logic        ex_valid, ex_taken, ex_ready;
  logic [15:0] ex_pc, ex_target;
  logic        id_valid, id_ready;
  logic [15:0] id_pc, id_target;
  logic        btb_we, btb_vld, busy;
  logic [7:0]  btb_idx, btb_tag;
  logic [15:0] btb_target;

  always #5 clk = ~clk;

  btb_update_ctrl #(.WORD_SIZE(16), .IDX_SIZE(8), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n), .flush_req(flush_req),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_ready(ex_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_target(id_target),
    .id_ready(id_ready),
    .btb_we(btb_we), .btb_idx(btb_idx), .btb_tag(btb_tag),
    .btb_target(btb_target), .btb_vld(btb_vld), .busy(busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: whole-BTB behaviour described as "clearing" vs "serving".
  bit clearing;     // sweep pending/in progress
  int sweep_pos;    // next entry to clear
  bit tail;         // final clear is on the port now
  int refused;      // consecutive ID refusals
  int e_we, e_idx, e_tag, e_tgt, e_vld;   // write expected on the port now
  bit ex_acc, id_acc;
  int we_run;       // consecutive cycles with a write presented

  task automatic step();
    bit er, ir;
    int n_we, n_idx, n_tag, n_tgt, n_vld;
    #1;
    if (!reset_n || clearing) begin
      er = 0; ir = 0;
    end else begin
      er = ex_valid && !(id_valid && refused == LIMIT);
      ir = id_valid && !er;
    end
    chk("ex_ready", ex_ready, er);
    chk("id_ready", id_ready, ir);
    chk("busy", busy, !reset_n || clearing || tail);
    chk("btb_we", btb_we, e_we);
    if (e_we) begin
      chk("btb_idx", btb_idx, e_idx);
      chk("btb_tag", btb_tag, e_tag);
      chk("btb_target", btb_target, e_tgt);
      chk("btb_vld", btb_vld, e_vld);
    end
    we_run = btb_we ? we_run + 1 : 0;
    ex_acc = er; id_acc = ir;
    n_we = 0; n_idx = 0; n_tag = 0; n_tgt = 0; n_vld = 0;
    if (!reset_n) begin
      clearing = 1; sweep_pos = 0; tail = 0; refused = 0;
    end else begin
      tail = clearing;
      if (clearing) begin
        n_we = 1; n_idx = sweep_pos;
        if (flush_req) sweep_pos = 0;
        else if (sweep_pos == DEPTH - 1) begin clearing = 0; sweep_pos = 0; end
        else sweep_pos++;
      end else begin
        if (er) begin
          n_we = 1; n_idx = ex_pc % 256; n_tag = ex_pc / 256;
          n_tgt = ex_taken ? int'(ex_target) : 0; n_vld = ex_taken;
        end else if (ir) begin
          n_we = 1; n_idx = id_pc % 256; n_tag = id_pc / 256;
          n_tgt = id_target; n_vld = 1;
        end
        if (flush_req) begin clearing = 1; sweep_pos = 0; end
      end
      if (id_valid && !ir) refused = (refused < LIMIT) ? refused + 1 : LIMIT;
      else refused = 0;
    end
    e_we = n_we; e_idx = n_idx; e_tag = n_tag; e_tgt = n_tgt; e_vld = n_vld;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_req = 0; ex_valid = 0; ex_taken = 0; ex_pc = '0; ex_target = '0;
    id_valid = 0; id_pc = '0; id_target = '0;
  endtask

  int ex_grants;

  initial begin
    reset_n = 0;
    idle_inputs();
    @(posedge clk); #1;
    clearing = 1; sweep_pos = 0; tail = 0; refused = 0;
    e_we = 0; e_idx = 0; e_tag = 0; e_tgt = 0; e_vld = 0; we_run = 0;
    step();                       // reset-state checks
    reset_n = 1;

    // Full clear sweep: 256 back-to-back writes
    for (int i = 0; i < DEPTH + 1; i++) step();
    chk("sweep_len", we_run, DEPTH);
    step();
    chk("busy_after_sweep", busy, 0);

    // Taken and not-taken EX updates
    ex_valid = 1; ex_taken = 1; ex_pc = 16'h1234; ex_target = 16'h2000;
    step();
    ex_taken = 0;
    step();
    idle_inputs();
    step();

    // Both requesters held: EX x4, then ID, repeating
    ex_valid = 1; ex_taken = 1; ex_pc = 16'h0a10; ex_target = 16'h0b00;
    id_valid = 1; id_pc = 16'h0c10; id_target = 16'h0d00;
    ex_grants = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (ex_acc) ex_grants++;
    end
    chk("ex_grants_in_15", ex_grants, 12);
    idle_inputs();
    step();

    // flush_req alongside an EX grant, then full sweep
    ex_valid = 1; ex_taken = 1; ex_pc = 16'h5678; ex_target = 16'h4444;
    flush_req = 1;
    step();
    idle_inputs();
    for (int i = 0; i < DEPTH + 3; i++) step();
    chk("busy_after_flush", busy, 0);

    // Reset mid-sweep at entry 100
    flush_req = 1; step(); flush_req = 0;
    for (int i = 0; i < 400 && !(clearing && sweep_pos == 100); i++) step();
    chk("reached_idx100", sweep_pos, 100);
    reset_n = 0; step(); reset_n = 1;
    for (int i = 0; i < DEPTH + 3; i++) step();
    chk("sweep_after_rst", busy, 0);

    // Idle in RUN: no writes
    for (int i = 0; i < 10; i++) step();
    chk("idle_no_we", we_run, 0);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      flush_req = ($urandom_range(199) == 0);
      reset_n   = ($urandom_range(599) != 0);
      if (clearing || !reset_n) begin
        ex_valid = 0; id_valid = 0;
      end else begin
        if (!ex_valid || ex_acc) begin
          ex_valid = $urandom_range(2) != 0; ex_taken = $urandom_range(1);
          ex_pc = 16'($urandom); ex_target = 16'($urandom);
          if ($urandom_range(3) == 0) ex_pc[7:0] = id_pc[7:0];
        end
        if (!id_valid || id_acc) begin
          id_valid = $urandom_range(2) != 0;
          id_pc = 16'($urandom); id_target = 16'($urandom);
        end
      end
      step();
    end
    reset_n = 1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d", n_total);
    $fatal(1);
  end

endmodule
